and_chain_sequencer: RTL and testbench
======================================

Name: and_chain_sequencer

Overview:
- Multi-cycle controller that computes an N-input bitwise AND by time-sharing one 2-input AND stage.
- Accumulates operands in order: partial[0] = op0 & op1, then partial[k] = partial[k-1] & op[k+1].
- Upstream and downstream connect through valid/ready handshakes.
- Sits in the logic-gate lab datapath as the sequenced replacement for a flat AND cascade, and exposes every intermediate partial result.

Parameters:
- N_IN, 4, number of operands; legal range is 2 to 16.
- W, 1, bit width of each operand; the AND is bitwise across the W bits.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand vector valid.
- in_ready  output  1  block can accept an operand vector.
- in_data  input  N_IN*W  operands; op[k] = in_data[k*W +: W], op0 in the LSBs.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_result  output  W  final AND of all operands.
- out_partial  output  (N_IN-1)*W  slot k = partial[k]; the last slot equals out_result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Single clock. Reset is asynchronous, active-low.
- While rst_n = 0: state = IDLE, in_ready = 1, out_valid = 0, busy = 0, out_result = 0, out_partial = 0, operand register = 0, step counter = 0.
- The FSM has three states: IDLE, STEP, DONE.
- IDLE:
  - in_ready = 1.
  - On a rising edge with in_valid = 1: capture in_data, set acc <= op0, clear out_partial and out_result, set step <= 1, go to STEP.
- STEP:
  - in_ready = 0.
  - Each edge: acc <= acc & op[step], partial[step-1] <= acc & op[step], step <= step + 1.
  - When step == N_IN-1 on that edge, also load out_result with the same value and go to DONE.
- DONE:
  - out_valid = 1. out_result and out_partial are stable.
  - On an edge with out_ready = 1, go to IDLE.
  - in_ready stays 0 throughout DONE; a new operand vector is never accepted in the same cycle the result is consumed.
- Latency: out_valid rises N_IN-1 cycles after the accepting edge (3 cycles at the default). Minimum spacing between accepted inputs is N_IN+1 cycles.
- Outputs hold their last values in IDLE until the next acceptance.
- in_valid while busy: ignored. Upstream must hold in_valid and in_data until in_ready = 1.
- out_ready while out_valid = 0: ignored.
- Reset mid-operation: asynchronous return to the reset values. The in-flight operation is discarded and no out_valid pulse is produced.
- Step counter width: clog2(N_IN), minimum 1. It never wraps, because the FSM leaves STEP at N_IN-1.

Optional Feature:
- Macro: AND_SEQ_EARLY_EXIT_EN.
- When defined, in STEP, if the newly computed partial is all-zero:
  - go to DONE immediately with out_result = 0;
  - the remaining out_partial slots stay 0.
  - Latency is then step cycles instead of N_IN-1.
- When undefined, all N_IN-1 steps always execute, giving fixed latency.

Decomposition:
- Package and_seq_pkg holds:
  - FSM state encoding constants (IDLE = 2'd0, STEP = 2'd1, DONE = 2'd2);
  - the step-counter width function;
  - the operand-slice helper.
- One sub-module, and_seq_stage: a registered 2-input W-bit AND with load enable, used for the acc and partial update.

Test Plan:
- Reset, then N_IN = 4, W = 1, in_data = 4'b1111 → out_valid rises 3 cycles after accept; out_result = 1; out_partial = 3'b111.
- in_data = 4'b0111 (op3 = 0) → out_partial = 3'b011, out_result = 0. With AND_SEQ_EARLY_EXIT_EN defined, latency is still 3 cycles.
- in_data = 4'b1110 (op0 = 0), without the macro → out_partial = 3'b000, out_result = 0, latency 3. With the macro → out_valid after 1 cycle, out_partial = 0.
- out_ready held 0 for 5 cycles in DONE, with in_valid = 1 continuously → out_valid and the data hold steady, in_ready stays 0. Releasing out_ready gives IDLE next cycle; the next vector is accepted one cycle later.
- Deassert rst_n during STEP (step = 2) → all outputs return to their reset values immediately, with no clock edge needed. A fresh vector 4'b1111 afterwards produces out_result = 1.
- W = 8, N_IN = 3, ops 8'hF0, 8'h3C, 8'hFF → out_partial = {8'h30, 8'h30}, out_result = 8'h30, latency 2.

Source files
------------

// File: rtl/and_seq_pkg.sv
// Shared FSM encoding and sizing/slicing helpers for the sequenced AND chain.
package and_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step counter must hold 1..N_IN-1; never narrower than one bit.
  function automatic int step_w(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

  // LSB position of operand k inside the packed operand bus.
  function automatic int op_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/and_seq_stage.sv
// Registered 2-input W-bit AND with synchronous clear (priority) and load enable.
module and_seq_stage #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (clr_i) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= a_i & b_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/and_chain_sequencer.sv
// N-input bitwise AND computed one operand per cycle through a shared 2-input stage.
// Optional build macro AND_SEQ_EARLY_EXIT_EN: finish as soon as a partial becomes all-zero.
module and_chain_sequencer
  import and_seq_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int W    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN*W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          out_result,
  output logic [(N_IN-1)*W-1:0] out_partial,
  output logic                  busy
);

  localparam int SW = step_w(N_IN);

  state_t            state_q, state_d;
  logic [SW-1:0]     step_q, step_d;
  logic [N_IN*W-1:0] op_q;
  logic [W-1:0]      acc_q, acc_a, acc_b;
  logic [W-1:0]      op_sel, new_val;
  logic              accept, step_en, last_step, early_zero, finish;

  assign accept    = (state_q == IDLE) && in_valid;
  assign step_en   = (state_q == STEP);
  assign new_val   = acc_q & op_sel;
  assign last_step = (step_q == SW'(N_IN - 1));
  assign finish    = step_en && (last_step || early_zero);

`ifdef AND_SEQ_EARLY_EXIT_EN
  assign early_zero = (new_val == '0);
`else
  assign early_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      if (accept) begin
        op_q <= in_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = STEP;
          step_d  = SW'(1);
        end
      end
      STEP: begin
        if (finish) begin
          state_d = DONE;
        end else begin
          step_d = step_q + SW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  // Operand for the current step, selected from the captured vector.
  always_comb begin
    op_sel = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (int'(step_q) == k) begin
        op_sel = op_q[op_lsb(k, W) +: W];
      end
    end
  end

  // Accumulator loads op0 on acceptance (ANDed with all-ones), then folds one operand per step.
  assign acc_a = accept ? in_data[W-1:0] : acc_q;
  assign acc_b = accept ? {W{1'b1}}      : op_sel;

  and_seq_stage #(.W(W)) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (1'b0),
    .en_i  (accept || step_en),
    .a_i   (acc_a),
    .b_i   (acc_b),
    .q_o   (acc_q)
  );

  for (genvar k = 0; k < N_IN - 1; k++) begin : g_part
    and_seq_stage #(.W(W)) u_part (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (accept),
      .en_i  (step_en && (step_q == SW'(k + 1))),
      .a_i   (acc_q),
      .b_i   (op_sel),
      .q_o   (out_partial[k*W +: W])
    );
  end

  and_seq_stage #(.W(W)) u_result (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (accept),
    .en_i  (finish),
    .a_i   (acc_q),
    .b_i   (op_sel),
    .q_o   (out_result)
  );

endmodule

// File: tb/tb_and_chain_sequencer.sv
// Randomized and directed bench for and_chain_sequencer (N_IN=4/W=1 and N_IN=3/W=8 instances).
module tb_and_chain_sequencer;

`ifdef AND_SEQ_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       iv, ir, ov, ordy, busy, res;
  logic [3:0] id;
  logic [2:0] part;

  logic        iv8, ir8, ov8, ordy8, busy8;
  logic [23:0] id8;
  logic [7:0]  res8;
  logic [15:0] part8;

  int n_vec = 0;
  int n_err = 0;

  and_chain_sequencer #(.N_IN(4), .W(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .in_data(id),
    .out_valid(ov), .out_ready(ordy), .out_result(res), .out_partial(part), .busy(busy)
  );

  and_chain_sequencer #(.N_IN(3), .W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
    .out_valid(ov8), .out_ready(ordy8), .out_result(res8), .out_partial(part8), .busy(busy8)
  );

  // Reference: fold operands left to right, recording each partial; optionally stop at zero.
  function automatic void model(input logic [127:0] data, input int n, input int w,
                                output logic [127:0] ep, output logic [15:0] er, output int el);
    logic [15:0] mask, p;
    mask = 16'((32'd1 << w) - 1);
    ep = '0;
    p  = 16'(data) & mask;
    el = n - 1;
    for (int k = 1; k < n; k++) begin
      p  = p & 16'(data >> (k * w)) & mask;
      ep = ep | (128'(p) << ((k - 1) * w));
      if (EARLY && p == 16'd0) begin
        el = k;
        break;
      end
    end
    er = p;
  endfunction

  task automatic drive4(input logic [3:0] d, output int lat);
    int guard = 0;
    while (!ir && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    iv = 1'b1; id = d;
    @(posedge clk); #1;
    iv = 1'b0;
    n_vec++;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ov) begin lat = c; break; end
    end
  endtask

  task automatic drive8(input logic [23:0] d, output int lat);
    int guard = 0;
    while (!ir8 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    iv8 = 1'b1; id8 = d;
    @(posedge clk); #1;
    iv8 = 1'b0;
    n_vec++;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ov8) begin lat = c; break; end
    end
  endtask

  task automatic release4();
    ordy = 1'b1; @(posedge clk); #1; ordy = 1'b0;
  endtask

  task automatic release8();
    ordy8 = 1'b1; @(posedge clk); #1; ordy8 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; iv = 0; id = '0; ordy = 0; iv8 = 0; id8 = '0; ordy8 = 0;
    #3;
    if ({ir, ov, busy, res, part} !== 7'b1000000) begin
      $display("FAIL reset4: got {ir,ov,busy,res,part}=%b want 1000000", {ir, ov, busy, res, part}); n_err++;
    end
    if ({ir8, ov8, busy8} !== 3'b100 || res8 !== 8'h00 || part8 !== 16'h0000) begin
      $display("FAIL reset8: got ir=%b ov=%b busy=%b res=%h part=%h want 1 0 0 00 0000",
               ir8, ov8, busy8, res8, part8); n_err++;
    end
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [3:0] vecs [3];
    logic [127:0] ep; logic [15:0] er; int el, lat;
    vecs[0] = 4'b1111; vecs[1] = 4'b0111; vecs[2] = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      model(128'(vecs[i]), 4, 1, ep, er, el);
      drive4(vecs[i], lat);
      if (lat !== el) begin
        $display("FAIL dir_latency[%b]: got %0d want %0d", vecs[i], lat, el); n_err++;
      end
      if (res !== er[0] || part !== ep[2:0]) begin
        $display("FAIL dir_data[%b]: got res=%b part=%b want res=%b part=%b",
                 vecs[i], res, part, er[0], ep[2:0]); n_err++;
      end
      release4();
      if (ir !== 1'b1 || ov !== 1'b0) begin
        $display("FAIL dir_release[%b]: got ir=%b ov=%b want 1 0", vecs[i], ir, ov); n_err++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] ep, ep2; logic [15:0] er, er2; int el, el2, lat;
    model(128'(4'b1011), 4, 1, ep, er, el);
    model(128'(4'b1101), 4, 1, ep2, er2, el2);
    drive4(4'b1011, lat);
    iv = 1'b1; id = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (ov !== 1'b1 || ir !== 1'b0 || res !== er[0] || part !== ep[2:0]) begin
        $display("FAIL bp_hold[%0d]: got ov=%b ir=%b res=%b part=%b want 1 0 %b %b",
                 i, ov, ir, res, part, er[0], ep[2:0]); n_err++;
      end
    end
    ordy = 1'b1; @(posedge clk); #1; ordy = 1'b0;
    if (ov !== 1'b0 || ir !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL bp_idle: got ov=%b ir=%b busy=%b want 0 1 0", ov, ir, busy); n_err++;
    end
    @(posedge clk); #1;
    iv = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || ir !== 1'b0) begin
      $display("FAIL bp_accept: got busy=%b ir=%b want 1 0", busy, ir); n_err++;
    end
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ov) begin lat = c; break; end
    end
    if (lat !== el2 || res !== er2[0] || part !== ep2[2:0]) begin
      $display("FAIL bp_next: got lat=%0d res=%b part=%b want %0d %b %b",
               lat, res, part, el2, er2[0], ep2[2:0]); n_err++;
    end
    release4();
  endtask

  task automatic test_mid_reset();
    int lat;
    iv = 1'b1; id = 4'b1111;
    @(posedge clk); #1;
    iv = 1'b0;
    @(posedge clk); #1;
    if (busy !== 1'b1 || part[0] !== 1'b1) begin
      $display("FAIL mr_inflight: got busy=%b part0=%b want 1 1", busy, part[0]); n_err++;
    end
    #2 rst_n = 1'b0;
    #1;
    if ({ir, ov, busy, res, part} !== 7'b1000000) begin
      $display("FAIL mr_async: got {ir,ov,busy,res,part}=%b want 1000000", {ir, ov, busy, res, part}); n_err++;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    if (ov !== 1'b0) begin
      $display("FAIL mr_nopulse: got ov=%b want 0", ov); n_err++;
    end
    drive4(4'b1111, lat);
    if (lat !== 3 || res !== 1'b1 || part !== 3'b111) begin
      $display("FAIL mr_fresh: got lat=%0d res=%b part=%b want 3 1 111", lat, res, part); n_err++;
    end
    release4();
  endtask

  task automatic test_random();
    logic [127:0] ep; logic [15:0] er; int el, lat, hold;
    logic [3:0] d;
    for (int i = 0; i < 25; i++) begin
      d = 4'($urandom | $urandom);
      model(128'(d), 4, 1, ep, er, el);
      drive4(d, lat);
      if (lat !== el || res !== er[0] || part !== ep[2:0]) begin
        $display("FAIL rand4[%0d] d=%b: got lat=%0d res=%b part=%b want %0d %b %b",
                 i, d, lat, res, part, el, er[0], ep[2:0]); n_err++;
      end
      hold = $urandom_range(0, 2);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        if (ov !== 1'b1 || res !== er[0]) begin
          $display("FAIL rand4_hold[%0d]: got ov=%b res=%b want 1 %b", i, ov, res, er[0]); n_err++;
        end
      end
      release4();
    end
  endtask

  task automatic test_wide();
    logic [127:0] ep; logic [15:0] er; int el, lat;
    logic [23:0] d;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) d = {8'hFF, 8'h3C, 8'hF0};
      else if (i == 1) d = {8'hA5, 8'h0F, 8'hF0};
      else d = 24'($urandom | $urandom | $urandom);
      model(128'(d), 3, 8, ep, er, el);
      drive8(d, lat);
      if (lat !== el || res8 !== er[7:0] || part8 !== ep[15:0]) begin
        $display("FAIL wide[%0d] d=%h: got lat=%0d res=%h part=%h want %0d %h %h",
                 i, d, lat, res8, part8, el, er[7:0], ep[15:0]); n_err++;
      end
      release8();
      if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
        $display("FAIL wide_release[%0d]: got ir=%b ov=%b want 1 0", i, ir8, ov8); n_err++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_mid_reset();
    test_random();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
